// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory responder: FSM state encoding,
// write/read opcode values, word-alignment mask and the captured request.
package data_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

  localparam logic [1:0] WORD_ALIGN = 2'b00;

  // Request as captured from the CPU bus in IDLE.
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/sp_ram.sv
// Single-port 32-bit RAM with synchronous write and registered read.
// Ports:
//   clk   - rising-edge clock
//   en    - access enable (no effect on contents or rdata when low)
//   we    - 1 = write wdata to addr, 0 = read addr into rdata
//   addr  - word address
//   wdata - write data
//   rdata - registered read data, holds until the next enabled read
module sp_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Read port: capture the addressed word only on an enabled read.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem[addr];
    end
  end

  // Contents are never reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// CPU data-memory responder: captures a request on CS, inserts WAIT_STATES
// wait cycles, performs one RAM access, then pulses READY (with ERR for
// misaligned or out-of-range requests). CS must drop before a new request.
// Ports:
//   CLK            - rising-edge clock
//   RST            - synchronous active-high reset
//   CS             - chip select, request active while high
//   WR_RD          - 1 = write, 0 = read
//   ADDR           - CPU byte address
//   Data_BUS_WRITE - CPU write data
//   Data_BUS_READ  - registered read data, held until the next good read
//   READY          - one-cycle completion pulse
//   ERR            - error flag, meaningful only with READY
module data_memory_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CS,
  input  logic        WR_RD,
  input  logic [31:0] ADDR,
  input  logic [31:0] Data_BUS_WRITE,
  output logic [31:0] Data_BUS_READ,
  output logic        READY,
  output logic        ERR
);

  localparam int unsigned CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES - 1);
  // Byte span of the memory, in 33 bits so a full 4 GiB span still fits.
  localparam logic [32:0] SPAN     = 33'd1 << (ADDR_W + 2);
  localparam state_e FIRST_ST      = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [31:0]       rd_data_q, rd_data_d;

  logic [32:0]       offset_c;
  logic              misalign_c;
  logic              range_err_c;
  logic              req_err_c;
  logic              ram_en_c;
  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [31:0]       ram_rdata;

  // Request decode: the borrow bit of the 33-bit subtraction flags addresses below the base.
  always_comb begin
    offset_c    = {1'b0, req_q.addr} - {1'b0, BASE_ADDR};
    misalign_c  = (req_q.addr[1:0] != WORD_ALIGN);
    range_err_c = offset_c[32] || (offset_c >= SPAN);
    req_err_c   = misalign_c || range_err_c;
    ram_addr_c  = offset_c[ADDR_W+1:2];
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    rd_data_d = rd_data_q;
    ram_en_c  = 1'b0;
    ram_we_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CS) begin
          req_d   = '{wr: WR_RD, addr: ADDR, wdata: Data_BUS_WRITE};
          cnt_d   = '0;
          state_d = FIRST_ST;
        end
      end

      ST_WAIT: begin
        if (!CS) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // RAM is touched only for a legal request; CS is ignored from here on.
      ST_ACCESS: begin
        ram_en_c = !req_err_c;
        ram_we_c = !req_err_c && (req_q.wr == OP_WR);
        state_d  = ST_DONE;
      end

      // Registered outputs load here, so READY is seen the cycle after DONE.
      ST_DONE: begin
        ready_d = 1'b1;
        err_d   = req_err_c;
        if (!req_err_c && (req_q.wr == OP_RD)) begin
          rd_data_d = ram_rdata;
        end
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        if (!CS) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

  sp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_ram (
    .clk   (CLK),
    .en    (ram_en_c),
    .we    (ram_we_c),
    .addr  (ram_addr_c),
    .wdata (req_q.wdata),
    .rdata (ram_rdata)
  );

  assign Data_BUS_READ = rd_data_q;
  assign READY         = ready_q;
  assign ERR           = err_q;

endmodule
